// File: rtl/reg_write_arbiter.sv
// reg_write_arbiter: round-robin arbiter sharing the register bank write port
// between two writeback requesters (req 0 = ALU, req 1 = load/immediate).
//
// Ports:
//   clk, rst_n            clock (rising edge), async active-low reset
//   hold                  suppress new grants; an in-flight write still completes
//   reqN_valid/addr/data  requester N write request
//   reqN_ready            requester N accepted this cycle (combinational)
//   write_enable/address/data  registered bank write port
//   pending_mask          one-hot of write_address while write_enable=1, else 0
//   conflict_count        saturating count of cycles with both valid and hold=0
module reg_write_arbiter #(
  parameter int unsigned BITS     = 8,
  parameter int unsigned REG_SIZE = 4,
  parameter int unsigned CNT_BITS = 8,
  localparam int unsigned AW      = (REG_SIZE > 1) ? $clog2(REG_SIZE) : 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                hold,
  input  logic                req0_valid,
  input  logic [AW-1:0]       req0_addr,
  input  logic [BITS-1:0]     req0_data,
  output logic                req0_ready,
  input  logic                req1_valid,
  input  logic [AW-1:0]       req1_addr,
  input  logic [BITS-1:0]     req1_data,
  output logic                req1_ready,
  output logic                write_enable,
  output logic [AW-1:0]       write_address,
  output logic [BITS-1:0]     write_data,
  output logic [REG_SIZE-1:0] pending_mask,
  output logic [CNT_BITS-1:0] conflict_count
);

  // Priority pointer: 0 favours req 0 on a tie, 1 favours req 1.
  logic            ptr_q;
  logic            grant0_c;
  logic            grant1_c;
  logic            any_grant_c;
  logic [AW-1:0]   win_addr_c;
  logic [BITS-1:0] win_data_c;

  // Grant selection; ties resolved by the pointer, nothing granted under hold.
  always_comb begin
    grant0_c = 1'b0;
    grant1_c = 1'b0;
    if (!hold) begin
      if (req0_valid && (!req1_valid || !ptr_q)) begin
        grant0_c = 1'b1;
      end else if (req1_valid) begin
        grant1_c = 1'b1;
      end
    end
  end

  assign any_grant_c = grant0_c | grant1_c;
  assign win_addr_c  = grant1_c ? req1_addr : req0_addr;
  assign win_data_c  = grant1_c ? req1_data : req0_data;

  // Readys are forced low while reset is asserted.
  assign req0_ready = rst_n & grant0_c;
  assign req1_ready = rst_n & grant1_c;

  // Bank write port register, pending mask and pointer update.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      write_enable  <= 1'b0;
      write_address <= '0;
      write_data    <= '0;
      pending_mask  <= '0;
      ptr_q         <= 1'b0;
    end else begin
      write_enable <= any_grant_c;
      if (any_grant_c) begin
        write_address <= win_addr_c;
        write_data    <= win_data_c;
        pending_mask  <= REG_SIZE'(1) << win_addr_c;
        // Last winner loses the next tie.
        ptr_q         <= grant0_c;
      end else begin
        pending_mask  <= '0;
      end
    end
  end

  // Saturating conflict counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      conflict_count <= '0;
    end else if (req0_valid && req1_valid && !hold &&
                 (conflict_count != {CNT_BITS{1'b1}})) begin
      conflict_count <= conflict_count + CNT_BITS'(1);
    end
  end

endmodule
